// File: rtl/phy_rx_deserializer.sv
// ============================================================================
//  Module   : phy_rx_deserializer
//  Brief    : Serial-to-lane receive deserializer with COM alignment hunting,
//             link-activity tracking and round-robin four-lane byte output.
//             Optional PHY_RX_ERRCNT_EN adds a saturating errCount output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_deserializer #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDL        = 8'h7C,
    parameter int         COM_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serialIn,
    output logic [7:0] dataOut0,
    output logic [7:0] dataOut1,
    output logic [7:0] dataOut2,
    output logic [7:0] dataOut3,
    output logic       validOut0,
    output logic       validOut1,
    output logic       validOut2,
    output logic       validOut3,
    output logic       active,
    output logic       byteStrobe
`ifdef PHY_RX_ERRCNT_EN
    ,
    output logic [7:0] errCount
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [4:0] C_THRESH = 5'(COM_THRESH);

    state_t      state_q, state_d;
    // Only the seven most recent bits are stored; the eighth is serialIn itself.
    logic [6:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  data_q [4];
    logic [7:0]  data_d [4];
    logic [3:0]  valid_q, valid_d;
    logic        active_q, active_d;
    logic        strobe_q, strobe_d;

    logic [7:0]  w_nxt;
    logic        w_is_com;
    logic        w_byte_done;
    logic        w_thresh_hit;

    assign w_nxt        = {sr_q, serialIn};
    assign w_is_com     = (w_nxt == COM);
    assign w_byte_done  = (bit_cnt_q == 3'd7);
    assign w_thresh_hit = (({1'b0, com_cnt_q} + 5'd1) == C_THRESH);

    always_comb begin
        state_d   = state_q;
        sr_d      = w_nxt[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        lane_d    = lane_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (w_is_com) begin
                    com_cnt_d = 4'd1;
                    bit_cnt_d = 3'd0;
                    if (COM_THRESH == 1) begin
                        state_d = ST_ACTIVE;
                        lane_d  = 2'd0;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (w_byte_done) begin
                    strobe_d = 1'b1;
                    if (w_is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (w_thresh_hit) begin
                            state_d = ST_ACTIVE;
                            lane_d  = 2'd0;
                        end
                    end else begin
                        state_d   = ST_HUNT;
                        com_cnt_d = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_byte_done) begin
                    strobe_d = 1'b1;
                    // A COM on a byte boundary means the transmitter went idle.
                    if (w_is_com) begin
                        state_d   = ST_LOCK;
                        com_cnt_d = 4'd1;
                        lane_d    = 2'd0;
                        valid_d   = 4'd0;
                    end else begin
                        data_d[lane_q]  = w_nxt;
                        valid_d[lane_q] = (w_nxt != IDL);
                        lane_d          = lane_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            lane_q    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 8'd0;
            end
            valid_q   <= 4'd0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
        end
    end

`ifdef PHY_RX_ERRCNT_EN
    logic [7:0] err_q;
    logic       w_fall;

    // Alignment loss in LOCK, or the link dropping out of ACTIVE.
    assign w_fall = w_byte_done &&
                    (((state_q == ST_LOCK) && !w_is_com) ||
                     ((state_q == ST_ACTIVE) && w_is_com));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 8'd0;
        end else if (w_fall && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign errCount = err_q;
`endif

    assign dataOut0   = data_q[0];
    assign dataOut1   = data_q[1];
    assign dataOut2   = data_q[2];
    assign dataOut3   = data_q[3];
    assign validOut0  = valid_q[0];
    assign validOut1  = valid_q[1];
    assign validOut2  = valid_q[2];
    assign validOut3  = valid_q[3];
    assign active     = active_q;
    assign byteStrobe = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_deserializer.sv
// ============================================================================
//  Module   : tb_phy_rx_deserializer
//  Brief    : Self-checking bench for phy_rx_deserializer: directed byte table,
//             reset corner cases and random serial traffic against a model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phy_rx_deserializer;

    localparam logic [7:0] C_COM    = 8'hBC;
    localparam logic [7:0] C_IDL    = 8'h7C;
    localparam int         C_THRESH = 4;

    logic       clk;
    logic       reset;
    logic       serialIn;
    logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
    logic       validOut0, validOut1, validOut2, validOut3;
    logic       active;
    logic       byteStrobe;
`ifdef PHY_RX_ERRCNT_EN
    logic [7:0] errCount;
`endif

    phy_rx_deserializer #(
        .COM        (C_COM),
        .IDL        (C_IDL),
        .COM_THRESH (C_THRESH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .serialIn   (serialIn),
        .dataOut0   (dataOut0),
        .dataOut1   (dataOut1),
        .dataOut2   (dataOut2),
        .dataOut3   (dataOut3),
        .validOut0  (validOut0),
        .validOut1  (validOut1),
        .validOut2  (validOut2),
        .validOut3  (validOut3),
        .active     (active),
        .byteStrobe (byteStrobe)
`ifdef PHY_RX_ERRCNT_EN
        ,
        .errCount   (errCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int strobe_seen = 0;

    // Reference model: alignment is remembered as the bit index of the locking
    // COM, and byte boundaries are every 8th bit after it.
    int         m_t;
    int         m_align;
    int         m_mode;       // 0 searching, 1 aligned/idle, 2 link up
    int         m_coms;
    int         m_lane;
    logic [7:0] m_win;
    logic [7:0] m_data [4];
    logic [3:0] m_val;
    logic       m_strobe;
    int         m_errs;

    task automatic model_reset();
        m_t = 0; m_align = 0; m_mode = 0; m_coms = 0; m_lane = 0;
        m_win = 8'd0; m_val = 4'd0; m_strobe = 1'b0; m_errs = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 8'd0;
    endtask

    task automatic model_bit(input logic b);
        m_t++;
        m_win    = {m_win[6:0], b};
        m_strobe = 1'b0;
        if (m_mode == 0) begin
            if (m_win == C_COM) begin
                m_align = m_t;
                m_coms  = 1;
                m_lane  = 0;
                m_mode  = (C_THRESH == 1) ? 2 : 1;
            end
        end else if (((m_t - m_align) % 8) == 0) begin
            m_strobe = 1'b1;
            if (m_mode == 1) begin
                if (m_win == C_COM) begin
                    m_coms++;
                    if (m_coms == C_THRESH) begin
                        m_mode = 2;
                        m_lane = 0;
                    end
                end else begin
                    m_mode = 0;
                    m_errs++;
                end
            end else begin
                if (m_win == C_COM) begin
                    m_mode = 1;
                    m_coms = 1;
                    m_lane = 0;
                    m_val  = 4'd0;
                    m_errs++;
                end else begin
                    m_data[m_lane] = m_win;
                    m_val[m_lane]  = (m_win != C_IDL);
                    m_lane         = (m_lane + 1) % 4;
                end
            end
        end
    endtask

    function automatic logic [37:0] dut_pack();
        return {dataOut3, dataOut2, dataOut1, dataOut0,
                validOut3, validOut2, validOut1, validOut0, active, byteStrobe};
    endfunction

    function automatic logic [37:0] model_pack();
        return {m_data[3], m_data[2], m_data[1], m_data[0], m_val, (m_mode == 2), m_strobe};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic b);
        serialIn = b;
        @(posedge clk);
        model_bit(b);
        #1;
        if (byteStrobe) strobe_seen++;
        check($sformatf("bit%0d", m_t), 64'(dut_pack()), 64'(model_pack()));
`ifdef PHY_RX_ERRCNT_EN
        check($sformatf("err%0d", m_t), 64'(errCount), 64'((m_errs > 255) ? 255 : m_errs));
`endif
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        serialIn = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset_clear", 64'(dut_pack()), 64'd0);
`ifdef PHY_RX_ERRCNT_EN
        check("reset_err", 64'(errCount), 64'd0);
`endif
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        act;
        logic        strb;
        logic [3:0]  val;
        logic [31:0] data;   // {lane3, lane2, lane1, lane0}
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic [7:0] rb;
        int         r;

        tbl[0]  = '{8'hBC, 1'b0, 1'b0, 4'b0000, 32'h0000_0000};
        tbl[1]  = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h0000_0000};
        tbl[2]  = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h0000_0000};
        tbl[3]  = '{8'hBC, 1'b1, 1'b1, 4'b0000, 32'h0000_0000};
        tbl[4]  = '{8'h11, 1'b1, 1'b1, 4'b0001, 32'h0000_0011};
        tbl[5]  = '{8'h22, 1'b1, 1'b1, 4'b0011, 32'h0000_2211};
        tbl[6]  = '{8'h33, 1'b1, 1'b1, 4'b0111, 32'h0033_2211};
        tbl[7]  = '{8'h44, 1'b1, 1'b1, 4'b1111, 32'h4433_2211};
        tbl[8]  = '{8'h55, 1'b1, 1'b1, 4'b1111, 32'h4433_2255};
        tbl[9]  = '{8'h66, 1'b1, 1'b1, 4'b1111, 32'h4433_6655};
        tbl[10] = '{8'h77, 1'b1, 1'b1, 4'b1111, 32'h4477_6655};
        tbl[11] = '{8'h88, 1'b1, 1'b1, 4'b1111, 32'h8877_6655};
        tbl[12] = '{8'hA0, 1'b1, 1'b1, 4'b1111, 32'h8877_66A0};
        tbl[13] = '{8'h7C, 1'b1, 1'b1, 4'b1101, 32'h8877_7CA0};
        tbl[14] = '{8'hA2, 1'b1, 1'b1, 4'b1101, 32'h88A2_7CA0};
        tbl[15] = '{8'h7C, 1'b1, 1'b1, 4'b0101, 32'h7CA2_7CA0};
        tbl[16] = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h7CA2_7CA0};
        tbl[17] = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h7CA2_7CA0};
        tbl[18] = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h7CA2_7CA0};
        tbl[19] = '{8'hBC, 1'b1, 1'b1, 4'b0000, 32'h7CA2_7CA0};
        tbl[20] = '{8'h99, 1'b1, 1'b1, 4'b0001, 32'h7CA2_7C99};
        tbl[21] = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h7CA2_7C99};
        tbl[22] = '{8'hBC, 1'b0, 1'b1, 4'b0000, 32'h7CA2_7C99};
        tbl[23] = '{8'h00, 1'b0, 1'b1, 4'b0000, 32'h7CA2_7C99};
        tbl[24] = '{8'h00, 1'b0, 1'b0, 4'b0000, 32'h7CA2_7C99};

        reset    = 1'b1;
        serialIn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 40; i++) step(1'b0);
        check("idle_no_strobe", 64'(strobe_seen), 64'd0);
        check("idle_inactive", 64'(active), 64'd0);

        for (int i = 0; i < 3; i++) step(1'b0);

        for (int k = 0; k < 25; k++) begin
            send_byte(tbl[k].b);
            check($sformatf("tbl%0d", k),
                  64'({dataOut3, dataOut2, dataOut1, dataOut0,
                       validOut3, validOut2, validOut1, validOut0, active, byteStrobe}),
                  64'({tbl[k].data, tbl[k].val, tbl[k].act, tbl[k].strb}));
`ifdef PHY_RX_ERRCNT_EN
            if (k == 23) check("err_after_fallback", 64'(errCount), 64'd3);
`endif
        end

        // Mid-byte reset while the link is up.
        repeat (4) send_byte(C_COM);
        send_byte(8'h5A);
        check("pre_rst_active", 64'(active), 64'd1);
        check("pre_rst_lane0", 64'({validOut0, dataOut0}), 64'({1'b1, 8'h5A}));
        step(1'b1); step(1'b0); step(1'b1);
        do_reset();
        send_byte(8'h5A);
        check("post_rst_quiet", 64'({active, validOut0, strobe_seen > 0 ? byteStrobe : 1'b0}), 64'd0);

        // Random traffic: COM runs, IDL, data and occasional bit slips.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 5) begin
                send_byte(C_COM);
            end else if (r == 5) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(1'($urandom));
            end else if (r == 6) begin
                send_byte(C_IDL);
            end else if (r == 7 && ($urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                rb = 8'($urandom);
                if (rb == C_COM) rb = 8'h00;
                send_byte(rb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
